// File: rtl/signal_ctrl_pkg.sv
// signal_ctrl_pkg: light encodings, phase enum and default timing for the multi-way signal controller
package signal_ctrl_pkg;
  typedef enum logic [1:0] {PH_GREEN = 2'd0, PH_YELLOW = 2'd1, PH_ALL_RED = 2'd2} phase_t;
  localparam logic [1:0] LT_RED = 2'b00;
  localparam logic [1:0] LT_YELLOW = 2'b01;
  localparam logic [1:0] LT_GREEN = 2'b11;
  localparam int DEF_NUM_WAYS = 4;
  localparam int DEF_MIN_GREEN = 5;
  localparam int DEF_MAX_GREEN = 20;
  localparam int DEF_YELLOW_TIME = 3;
  localparam int DEF_ALL_RED_TIME = 2;
  function automatic logic [1:0] light_of(phase_t ph);
    return ph == PH_GREEN ? LT_GREEN : ph == PH_YELLOW ? LT_YELLOW : LT_RED;
  endfunction
endpackage

// File: rtl/multi_way_signal_controller_rr_way_select.sv
// rr_way_select: first pending way after current, wrapping to 0; holds current when none is pending
module rr_way_select #(
  parameter int NUM_WAYS = 4
) (
  input  logic [NUM_WAYS-1:0]         pending,
  input  logic [$clog2(NUM_WAYS)-1:0] current,
  output logic [$clog2(NUM_WAYS)-1:0] next
);
  localparam int WW = $clog2(NUM_WAYS);
  always_comb begin
    next = current;
    for (int i = NUM_WAYS - 1; i >= 1; i--)
      if (pending[(int'(current) + i) % NUM_WAYS]) next = WW'((int'(current) + i) % NUM_WAYS);
  end
endmodule

// File: rtl/multi_way_signal_controller.sv
// multi_way_signal_controller: round-robin N-way traffic light FSM (GREEN/YELLOW/ALL_RED).
// Define EMERGENCY_PREEMPT_EN to add the preempt_req/preempt_way/preempt_active emergency override.
module multi_way_signal_controller
  import signal_ctrl_pkg::*;
#(
  parameter int NUM_WAYS     = DEF_NUM_WAYS,
  parameter int MIN_GREEN    = DEF_MIN_GREEN,
  parameter int MAX_GREEN    = DEF_MAX_GREEN,
  parameter int YELLOW_TIME  = DEF_YELLOW_TIME,
  parameter int ALL_RED_TIME = DEF_ALL_RED_TIME
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_WAYS-1:0]         sensor,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic                        preempt_req,
  input  logic [$clog2(NUM_WAYS)-1:0] preempt_way,
  output logic                        preempt_active,
`endif
  output logic [2*NUM_WAYS-1:0]       lights,
  output logic [$clog2(NUM_WAYS)-1:0] active_way,
  output logic [1:0]                  phase
);
  localparam int WW = $clog2(NUM_WAYS);
  localparam int CW = $clog2(MAX_GREEN + YELLOW_TIME + ALL_RED_TIME + 1);
  phase_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [NUM_WAYS-1:0] pend, pend_n, active_oh;
  logic [WW-1:0] rr_way, sel_way, way_n;
  logic [2*NUM_WAYS-1:0] lights_n;
  logic green_done, green_exit, enter_green;
  rr_way_select #(.NUM_WAYS(NUM_WAYS)) u_rr (.pending(pend), .current(active_way), .next(rr_way));
  assign active_oh = NUM_WAYS'(1) << active_way;
  assign green_done = |(pend & ~active_oh) &&
                      ((cnt >= CW'(MIN_GREEN - 1) && !sensor[active_way]) || cnt == CW'(MAX_GREEN - 1));
`ifdef EMERGENCY_PREEMPT_EN
  logic pv;
  assign pv = preempt_req && (int'(preempt_way) < NUM_WAYS);
  // A valid preempt forces the change (or holds GREEN if it targets the active way).
  assign green_exit = pv ? (preempt_way != active_way) : green_done;
  assign sel_way = pv ? preempt_way : rr_way;
  always_ff @(posedge clk or posedge reset)
    if (reset) preempt_active <= 1'b0;
    else preempt_active <= pv;
`else
  assign green_exit = green_done;
  assign sel_way = rr_way;
`endif
  always_comb begin
    st_n = (st == PH_GREEN && green_exit) ? PH_YELLOW :
           (st == PH_YELLOW && cnt == CW'(YELLOW_TIME - 1)) ? PH_ALL_RED :
           (st == PH_ALL_RED && cnt == CW'(ALL_RED_TIME - 1)) ? PH_GREEN : st;
    enter_green = st == PH_ALL_RED && st_n == PH_GREEN;
    way_n = enter_green ? sel_way : active_way;
    cnt_n = st_n != st ? '0 : (st == PH_GREEN && cnt == CW'(MAX_GREEN - 1)) ? cnt : cnt + CW'(1);
    pend_n = (pend | (sensor & ~(st == PH_GREEN ? active_oh : '0))) &
             ~(enter_green ? NUM_WAYS'(1) << way_n : '0);
    lights_n = '0;
    for (int i = 0; i < NUM_WAYS; i++)
      lights_n[2*i +: 2] = (i == int'(way_n)) ? light_of(st_n) : LT_RED;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= PH_GREEN;
      cnt <= '0;
      pend <= '0;
      active_way <= '0;
      lights <= {{(2*NUM_WAYS-2){1'b0}}, LT_GREEN};
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      pend <= pend_n;
      active_way <= way_n;
      lights <= lights_n;
    end
  assign phase = st;
endmodule
